// File: rtl/memory_writeback_pkg.sv
// Shared pipeline definitions for the memory/writeback stage: funct3 access encodings,
// FSM state type and byte-enable width helper.
package memory_writeback_pkg;

    localparam int unsigned F3_W = 3;

    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    // One byte enable per data byte.
    function automatic int unsigned mask_width(input int unsigned dwidth);
        return dwidth / 8;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane selection plus sign/zero extension for loads.
module load_store_align
    import memory_writeback_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [F3_W-1:0]                  funct3_i,
    input  logic [1:0]                       off_i,
    input  logic [DWIDTH-1:0]                st_data_i,
    input  logic [DWIDTH-1:0]                ld_word_i,
    output logic [DWIDTH-1:0]                st_wdata_o,
    output logic [mask_width(DWIDTH)-1:0]    st_wmask_o,
    output logic [DWIDTH-1:0]                ld_data_o
);
    localparam int unsigned MW = mask_width(DWIDTH);

    logic [DWIDTH-1:0] lane_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    // Store: replicate the datum across lanes, enable only the addressed bytes.
    always_comb begin
        st_wdata_o = st_data_i;
        st_wmask_o = {MW{1'b1}};
        case (funct3_i[1:0])
            F3_LB[1:0]: begin
                st_wdata_o = {(DWIDTH/8){st_data_i[7:0]}};
                st_wmask_o = MW'(1) << off_i;
            end
            F3_LH[1:0]: begin
                st_wdata_o = {(DWIDTH/16){st_data_i[15:0]}};
                st_wmask_o = MW'(3) << {off_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Load: shift the addressed lane down, then extend.
    always_comb begin
        lane_word = ld_word_i >> {off_i, 3'b000};
        ld_byte   = lane_word[7:0];
        ld_half   = lane_word[15:0];
        ld_data_o = ld_word_i;
        case (funct3_i)
            F3_LB:   ld_data_o = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data_o = {{(DWIDTH-16){ld_half[15]}}, ld_half};
            F3_LBU:  ld_data_o = {{(DWIDTH-8){1'b0}}, ld_byte};
            F3_LHU:  ld_data_o = {{(DWIDTH-16){1'b0}}, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/memory_writeback.sv
// Memory access + writeback stage: retires ALU results, runs one data-memory transaction per
// load/store. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking.
module memory_writeback
    import memory_writeback_pkg::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 5,
    parameter int unsigned FUNCT_WIDTH = 3
) (
    input  logic                            me_clk,
    input  logic                            me_rst,
    input  logic                            me_i_ce,
    input  logic                            me_i_flush,
    input  logic                            me_i_load,
    input  logic                            me_i_store,
    input  logic [FUNCT_WIDTH-1:0]          me_i_funct3,
    input  logic [DWIDTH-1:0]               me_i_alu_value,
    input  logic [DWIDTH-1:0]               me_i_data_rs2,
    input  logic [AWIDTH-1:0]               me_i_addr_rd,
    input  logic                            me_i_we_reg,
    output logic                            me_o_stall,
    output logic                            me_o_mem_req,
    output logic                            me_o_mem_we,
    output logic [DWIDTH-1:0]               me_o_mem_addr,
    output logic [DWIDTH-1:0]               me_o_mem_wdata,
    output logic [mask_width(DWIDTH)-1:0]   me_o_mem_wmask,
    input  logic                            me_i_mem_ack,
    input  logic [DWIDTH-1:0]               me_i_mem_rdata,
    output logic                            me_o_valid,
    output logic                            me_o_we_reg,
    output logic [AWIDTH-1:0]               me_o_addr_rd,
    output logic [DWIDTH-1:0]               me_o_data_rd,
    output logic                            me_o_misalign
);
    localparam int unsigned MW = mask_width(DWIDTH);

    state_e            state_q, state_d;
    logic [F3_W-1:0]   funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic              load_q, load_d, we_reg_q, we_reg_d, kill_q, kill_d;
    logic [AWIDTH-1:0] rd_q, rd_d;
    logic              req_q, req_d, mem_we_q, mem_we_d;
    logic [DWIDTH-1:0] mem_addr_q, mem_addr_d, wdata_q, wdata_d;
    logic [MW-1:0]     wmask_q, wmask_d;
    logic              valid_q, valid_d, we_q, we_d, misalign_q, misalign_d;
    logic [AWIDTH-1:0] addr_rd_q, addr_rd_d;
    logic [DWIDTH-1:0] data_rd_q, data_rd_d;

    logic [F3_W-1:0]   in_funct3, sel_funct3;
    logic [1:0]        in_off, sel_off;
    logic              accept, is_mem, is_half, is_word, misalign_c;
    logic [DWIDTH-1:0] st_wdata, ld_data;
    logic [MW-1:0]     st_wmask;

    assign in_funct3 = F3_W'(me_i_funct3);
    assign accept    = (state_q == ST_IDLE) && me_i_ce && !me_i_flush;
    assign is_mem    = me_i_load || me_i_store;
    assign is_half   = (in_funct3[1:0] == F3_LH[1:0]);
    assign is_word   = in_funct3[1];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_c = is_mem && ((is_half && me_i_alu_value[0]) ||
                                   (is_word && (me_i_alu_value[1:0] != 2'b00)));
    assign in_off     = me_i_alu_value[1:0];
    assign me_o_misalign = misalign_q;
`else
    // Low address bits below the access size are dropped rather than trapped.
    assign misalign_c = 1'b0;
    assign in_off     = is_word ? 2'b00 :
                        is_half ? {me_i_alu_value[1], 1'b0} : me_i_alu_value[1:0];
    assign me_o_misalign = 1'b0;
`endif

    assign sel_funct3 = (state_q == ST_IDLE) ? in_funct3 : funct3_q;
    assign sel_off    = (state_q == ST_IDLE) ? in_off    : off_q;

    load_store_align #(.DWIDTH(DWIDTH)) u_align (
        .funct3_i   (sel_funct3),
        .off_i      (sel_off),
        .st_data_i  (me_i_data_rs2),
        .ld_word_i  (me_i_mem_rdata),
        .st_wdata_o (st_wdata),
        .st_wmask_o (st_wmask),
        .ld_data_o  (ld_data)
    );

    always_ff @(posedge me_clk) begin
        if (me_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept && is_mem && !misalign_c) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (me_i_mem_ack) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Next values of registered outputs and transaction context; pulses default low.
    always_comb begin
        funct3_d   = funct3_q;
        off_d      = off_q;
        load_d     = load_q;
        we_reg_d   = we_reg_q;
        kill_d     = kill_q;
        rd_d       = rd_q;
        req_d      = req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        addr_rd_d  = addr_rd_q;
        data_rd_d  = data_rd_q;
        valid_d    = 1'b0;
        we_d       = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (accept) begin
                    if (!is_mem) begin
                        valid_d   = 1'b1;
                        we_d      = me_i_we_reg && (me_i_addr_rd != '0);
                        addr_rd_d = me_i_addr_rd;
                        data_rd_d = me_i_alu_value;
                    end else if (misalign_c) begin
                        misalign_d = 1'b1;
                    end else begin
                        req_d      = 1'b1;
                        mem_we_d   = me_i_store;
                        mem_addr_d = {me_i_alu_value[DWIDTH-1:2], 2'b00};
                        wdata_d    = st_wdata;
                        wmask_d    = st_wmask;
                        funct3_d   = in_funct3;
                        off_d      = in_off;
                        load_d     = !me_i_store;
                        we_reg_d   = me_i_we_reg;
                        rd_d       = me_i_addr_rd;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (me_i_flush) kill_d = 1'b1;
                if (me_i_mem_ack) begin
                    req_d = 1'b0;
                    if (!kill_q && !me_i_flush) begin
                        valid_d   = 1'b1;
                        addr_rd_d = rd_q;
                        if (load_q) begin
                            data_rd_d = ld_data;
                            we_d      = we_reg_q && (rd_q != '0);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge me_clk) begin
        if (me_rst) begin
            funct3_q   <= '0;
            off_q      <= '0;
            load_q     <= 1'b0;
            we_reg_q   <= 1'b0;
            kill_q     <= 1'b0;
            rd_q       <= '0;
            req_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            misalign_q <= 1'b0;
            addr_rd_q  <= '0;
            data_rd_q  <= '0;
        end else begin
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            load_q     <= load_d;
            we_reg_q   <= we_reg_d;
            kill_q     <= kill_d;
            rd_q       <= rd_d;
            req_q      <= req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            valid_q    <= valid_d;
            we_q       <= we_d;
            misalign_q <= misalign_d;
            addr_rd_q  <= addr_rd_d;
            data_rd_q  <= data_rd_d;
        end
    end

    assign me_o_stall     = (state_q == ST_MEM_WAIT);
    assign me_o_mem_req   = req_q;
    assign me_o_mem_we    = mem_we_q;
    assign me_o_mem_addr  = mem_addr_q;
    assign me_o_mem_wdata = wdata_q;
    assign me_o_mem_wmask = wmask_q;
    assign me_o_valid     = valid_q;
    assign me_o_we_reg    = we_q;
    assign me_o_addr_rd   = addr_rd_q;
    assign me_o_data_rd   = data_rd_q;

endmodule

// File: doc/memory_writeback.md
MEMORY_WRITEBACK -- requirements
Module: memory_writeback

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data/address width.
REQ-002 SHALL have parameter AWIDTH, default 5, register address width.
REQ-003 SHALL have parameter FUNCT_WIDTH, default 3, funct3 width.
REQ-004 SHALL provide these ports:
- me_clk  in  1  sole clock, rising edge.
- me_rst  in  1  synchronous, active-high reset.
- me_i_ce  in  1  execute result valid.
- me_i_flush  in  1  kill current/incoming instruction.
- me_i_load  in  1  instruction is a load.
- me_i_store  in  1  instruction is a store.
- me_i_funct3  in  FUNCT_WIDTH  access size/sign.
- me_i_alu_value  in  DWIDTH  ALU result or effective address.
- me_i_data_rs2  in  DWIDTH  store data.
- me_i_addr_rd  in  AWIDTH  destination register.
- me_i_we_reg  in  1  destination write requested.
- me_o_stall  out  1  upstream must hold.
- me_o_mem_req  out  1  data-memory request.
- me_o_mem_we  out  1  1 = write.
- me_o_mem_addr  out  DWIDTH  word-aligned address.
- me_o_mem_wdata  out  DWIDTH  lane-steered store data.
- me_o_mem_wmask  out  DWIDTH/8  byte enables.
- me_i_mem_ack  in  1  request completed.
- me_i_mem_rdata  in  DWIDTH  read word, valid with ack.
- me_o_valid  out  1  one-cycle retire pulse.
- me_o_we_reg  out  1  register-file write enable.
- me_o_addr_rd  out  AWIDTH  writeback address.
- me_o_data_rd  out  DWIDTH  writeback data.
- me_o_misalign  out  1  misaligned-access pulse.

Function
REQ-005 SHALL implement states IDLE and MEM_WAIT.
REQ-006 In IDLE, SHALL accept an instruction when me_i_ce=1 and me_i_flush=0.
REQ-007 A non-memory instruction SHALL retire the cycle after acceptance: me_o_valid=1, me_o_data_rd=me_i_alu_value, me_o_we_reg=me_i_we_reg AND (addr_rd!=0).
REQ-008 A load/store SHALL assert me_o_mem_req from the cycle after acceptance and enter MEM_WAIT.
REQ-009 In MEM_WAIT, req/we/addr/wdata/wmask SHALL remain stable until the edge where me_i_mem_ack=1; req deasserts the following cycle.
REQ-010 me_o_stall SHALL be 1 exactly while in MEM_WAIT (combinational from state).
REQ-011 Stores: SB mask 0001<<addr[1:0], byte replicated; SH mask 0011<<{addr[1],0}, half replicated; SW mask 1111.
REQ-012 Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through, selecting lanes by addr[1:0].
REQ-013 On ack, a load SHALL retire next cycle with extended data; a store SHALL retire with me_o_we_reg=0.
REQ-014 An ack arriving in the first request cycle SHALL be honoured (single-cycle memory).
REQ-015 me_i_mem_ack outside MEM_WAIT SHALL be ignored.
REQ-016 me_i_flush in MEM_WAIT SHALL NOT abort the bus transaction but SHALL suppress that instruction's retire pulse.
REQ-017 me_o_valid, me_o_we_reg, and me_o_misalign SHALL be single-cycle pulses; data/address outputs hold their last values otherwise.

Reset
REQ-018 me_rst SHALL force IDLE and drive all outputs to 0 on the next edge, including mid-transaction (request dropped, no retire).

Configuration
REQ-019 With MEM_MISALIGN_TRAP_EN defined:
- LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL issue no request.
- me_o_misalign SHALL pulse the cycle after acceptance.
- No register write SHALL occur.
REQ-020 Without MEM_MISALIGN_TRAP_EN:
- me_o_misalign SHALL be tied to 0.
- Ignored low address bits SHALL be treated as 0 (addr[0] for halves, addr[1:0] for words).

Structure
REQ-021 funct3 encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101) and the mask width SHALL reside in the shared pipeline package.
REQ-022 Lane steering and extension SHALL be one combinational sub-module, load_store_align.

Verification
REQ-023 ADD retire: alu_value=0x0000002A, rd=5, we=1 -> next cycle valid=1, we_reg=1, data_rd=42, addr_rd=5, stall=0.
REQ-024 SB: addr=0x103, rs2=0x000000AB, ack after 3 cycles -> mem_addr=0x100, wmask=1000, wdata=0xABABABAB, stall=1 for 3 cycles, valid with we_reg=0.
REQ-025 LB: addr=0x101, rdata=0x0000F000 -> data_rd=0xFFFFFFF0; LBU, same input -> 0x000000F0.
REQ-026 LW, rd=0: same-cycle ack -> req high one cycle, valid=1, we_reg=0.
REQ-027 Flush during MEM_WAIT, then ack -> req completes, no valid pulse; reset mid-MEM_WAIT -> req=0 next cycle, state IDLE.
REQ-028 With MEM_MISALIGN_TRAP_EN, LW addr=0x102 -> misalign pulse, req never asserted, valid=0.
